sdram0_arbiter: RTL

Two-master arbiter for the HPS f2h_sdram0 Avalon-MM slave port, shared between the front-buffer scan-out reader (master 0) and the render/clear engine (master 1). Sits between the framebuffer clients and the soc_system sdram0 data interface, all in the memory clock domain. Grants one whole burst transaction at a time and routes commands, write data and read beats between the winner and the slave. Scan-out has priority so the HDMI path never underruns.

---
 rtl/sdram0_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sdram0_arbiter.sv
// -----------------------------------------------------------------------------
// sdram0_arbiter
//
// Two-master arbiter in front of the HPS f2h_sdram0 Avalon-MM slave port.
// Master 0 is the front-buffer scan-out reader, master 1 the render/clear
// engine. One whole burst transaction is granted at a time; the winner's
// command, write data and byte enables are passed combinationally to the
// slave, and read beats are routed back to the owner only.
//
// Build option:
//   SDRAM0_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                     undefined -> fixed priority, master 0 wins ties
//
// Ports:
//   clock, reset                 memory clock, synchronous active-high reset
//   mN_address/burstcount        master N command address / burst length
//   mN_read/mN_write             master N command strobes
//   mN_writedata/mN_byteenable   master N write beat and byte lanes
//   mN_waitrequest               stall to master N (1 unless it owns the port)
//   mN_readdata                  slave readdata, broadcast to both masters
//   mN_readdatavalid             read beat valid, asserted for the owner only
//   s_*                          Avalon-MM master side toward sdram0
// -----------------------------------------------------------------------------
module sdram0_arbiter #(
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [BURST_W-1:0]    m0_burstcount,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [BURST_W-1:0]    m1_burstcount,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic [BURST_W-1:0]    s_burstcount,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid
);

    typedef enum logic [1:0] {IDLE, CMD, WBURST, RDATA} state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [BURST_W-1:0]   beats_left_q, beats_left_d;

    logic                 req0, req1, winner;
    logic                 g_read, g_write;
    logic [ADDR_W-1:0]    g_address;
    logic [BURST_W-1:0]   g_burstcount, g_bc_eff;
    logic [DATA_W-1:0]    g_writedata;
    logic [DATA_W/8-1:0]  g_byteenable;
    logic                 g_wait;
    logic                 rdv;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef SDRAM0_ARB_RR_EN
    // Tie goes to whoever did not win last time; a lone requester always wins.
    assign winner = (req0 && req1) ? ~last_grant_q : ~req0;
`else
    // Scan-out must never underrun, so master 0 takes every tie.
    assign winner = ~req0;
`endif

    // View of the currently granted master.
    always_comb begin
        if (grant_q) begin
            g_read       = m1_read;
            g_write      = m1_write;
            g_address    = m1_address;
            g_burstcount = m1_burstcount;
            g_writedata  = m1_writedata;
            g_byteenable = m1_byteenable;
        end else begin
            g_read       = m0_read;
            g_write      = m0_write;
            g_address    = m0_address;
            g_burstcount = m0_burstcount;
            g_writedata  = m0_writedata;
            g_byteenable = m0_byteenable;
        end
    end

    // A burstcount of 0 is served as a single beat.
    assign g_bc_eff = (g_burstcount == '0) ? BURST_W'(1) : g_burstcount;

    assign s_address    = g_address;
    assign s_burstcount = g_bc_eff;
    assign s_writedata  = g_writedata;
    assign s_byteenable = g_byteenable;
    // A master presenting both strobes is treated as reading.
    assign s_read  = (state_q == CMD) & g_read;
    assign s_write = ((state_q == CMD) & g_write & ~g_read) |
                     ((state_q == WBURST) & g_write);

    // Only the owner sees the slave's stall, and only while it may issue.
    assign g_wait         = ((state_q == CMD) || (state_q == WBURST)) ? s_waitrequest : 1'b1;
    assign m0_waitrequest = grant_q ? 1'b1 : g_wait;
    assign m1_waitrequest = grant_q ? g_wait : 1'b1;

    // Read beats outside RDATA are strays (e.g. left over across a reset).
    assign rdv              = (state_q == RDATA) & s_readdatavalid;
    assign m0_readdatavalid = rdv & ~grant_q;
    assign m1_readdatavalid = rdv & grant_q;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beats_left_d = beats_left_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (s_read && !s_waitrequest) begin
                    beats_left_d = g_bc_eff;
                    state_d      = RDATA;
                end else if (s_write && !s_waitrequest) begin
                    if (g_bc_eff == BURST_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        beats_left_d = g_bc_eff - BURST_W'(1);
                        state_d      = WBURST;
                    end
                end else if (!g_read && !g_write) begin
                    // Owner withdrew before the slave took the command.
                    state_d = IDLE;
                end
            end
            WBURST: begin
                if (s_write && !s_waitrequest) begin
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RDATA: begin
                if (s_readdatavalid) begin
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule
